// File: rtl/fetch_stage.sv
// fetch_stage: one-insn-per-cycle PC/ROM fetch with redirect squash and stall hold; optional FETCH_PERF_EN counters
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          IMEM_AW  = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_q,
    output logic [31:0]        fd_pc_plus_1,
    output logic [31:0]        fd_insn,
    output logic               fd_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
`endif
);
    logic [31:0] npc_q, npc_d, pc_q, pc_d;
    logic        valid_q, valid_d;
    always_comb begin
        fd_valid     = valid_q & ~redirect;
        fd_insn      = fd_valid ? imem_q : 32'd0;
        fd_pc_plus_1 = pc_q + 32'd1;
        // stall re-reads the in-flight PC so the ROM output stays put
        imem_addr    = redirect ? redirect_pc[IMEM_AW-1:0] : stall ? pc_q[IMEM_AW-1:0] : npc_q[IMEM_AW-1:0];
        npc_d        = redirect ? redirect_pc + 32'd1 : stall ? npc_q : npc_q + 32'd1;
        pc_d         = redirect ? redirect_pc : stall ? pc_q : npc_q;
        valid_d      = redirect ? 1'b1 : stall ? valid_q : 1'b1;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            npc_q   <= RESET_PC;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            npc_q   <= npc_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end
`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d, bubbles_q, bubbles_d;
    always_comb begin
        fetched_d    = fetched_q + 32'(fd_valid & ~stall);
        bubbles_d    = bubbles_q + 32'(~fd_valid);
        perf_fetched = fetched_q;
        perf_bubbles = bubbles_q;
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            fetched_q <= 32'd0;
            bubbles_q <= 32'd0;
        end else begin
            fetched_q <= fetched_d;
            bubbles_q <= bubbles_d;
        end
    end
`endif
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, meaning the PC loaded by reset.
REQ-002 SHALL have parameter IMEM_AW, default 12, meaning the instruction-memory address width.
REQ-003 SHALL have port clock, input, 1, the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-low reset (0 = reset).
REQ-005 SHALL have port stall, input, 1, meaning hold fetch because FD cannot accept.
REQ-006 SHALL have port redirect, input, 1, meaning a taken branch or jump resolved downstream.
REQ-007 SHALL have port redirect_pc, input, 32, the redirect target PC.
REQ-008 SHALL have port imem_addr, output, IMEM_AW, the address to a synchronous ROM whose data appears one cycle after the address.
REQ-009 SHALL have port imem_q, input, 32, the ROM read data.
REQ-010 SHALL have port fd_pc_plus_1, output, 32, PC+1 of the delivered instruction, driving FD latch pc_plus_1.
REQ-011 SHALL have port fd_insn, output, 32, the delivered instruction, driving FD latch pc_insn.
REQ-012 SHALL have port fd_valid, output, 1, meaning fd_insn is a real instruction.

Function
REQ-013 SHALL hold registers pc (next PC to fetch, 32b), pc_q (PC of the instruction in flight, 32b) and valid_q (1b).
REQ-014 SHALL drive imem_addr from a mux with priority redirect > stall > normal: redirect_pc[IMEM_AW-1:0], else pc_q[IMEM_AW-1:0], else pc[IMEM_AW-1:0].
REQ-015 SHALL drive fd_insn = imem_q when fd_valid, else 32'd0 (nop).
REQ-016 SHALL drive fd_pc_plus_1 = pc_q + 1 (mod 2^32).
REQ-017 SHALL drive fd_valid = valid_q & ~redirect (combinational squash in the redirect cycle).
REQ-018 On a normal cycle (no redirect, no stall), SHALL update pc_q <= pc, pc <= pc + 1 and valid_q <= 1.
REQ-019 On a stall cycle without redirect, SHALL hold pc, pc_q and valid_q, re-read the ROM at pc_q and keep the outputs stable.
REQ-020 On redirect (regardless of stall), SHALL update pc_q <= redirect_pc, pc <= redirect_pc + 1 and valid_q <= 1, so the target instruction is delivered the next cycle with zero extra bubbles.
REQ-021 SHALL let PC arithmetic wrap, so 32'hFFFFFFFF + 1 = 0, and imem_addr SHALL use the low IMEM_AW bits only.
REQ-022 SHALL have a steady-state throughput of one instruction per cycle and a latency from address to fd_insn of 1 cycle.

Reset
REQ-023 While reset=0 at a clock edge, SHALL set pc <= RESET_PC, pc_q <= RESET_PC and valid_q <= 0; reset SHALL override redirect and stall.
REQ-024 In the first cycle after release, SHALL output fd_valid=0, fd_insn=0 and fd_pc_plus_1=RESET_PC+1 (one startup bubble); the second cycle SHALL deliver insn[RESET_PC].
REQ-025 A reset asserted mid-stream SHALL discard any in-flight instruction and follow REQ-024 on release.

Configuration
REQ-026 With macro FETCH_PERF_EN defined, SHALL add outputs perf_fetched (32) and perf_bubbles (32), both reset to 0 and wrapping.
REQ-027 perf_fetched SHALL increment on cycles with fd_valid=1 and stall=0; perf_bubbles SHALL increment on cycles with fd_valid=0.
REQ-028 Without FETCH_PERF_EN, these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 Reset then free-run with ROM[i]=0x1000+i and RESET_PC=0 -> cycle 1 fd_valid=0; cycles 2..5 deliver insn 0x1000..0x1003 with fd_pc_plus_1 1..4.
REQ-030 stall=1 for 3 cycles while delivering insn 0x1002 -> fd_insn=0x1002 and fd_pc_plus_1=3 held all 3 cycles; 0x1003 follows the release.
REQ-031 redirect=1 with redirect_pc=0x40 -> that cycle fd_valid=0 and fd_insn=0; the next cycle fd_insn=ROM[0x40] and fd_pc_plus_1=0x41.
REQ-032 redirect and stall both 1 with redirect_pc=0x80 -> redirect wins; the next cycle delivers ROM[0x80].
REQ-033 redirect_pc=32'hFFFFFFFF -> fd_pc_plus_1=0 and imem_addr=12'hFFF, then the following fetch uses address 0.
REQ-034 With FETCH_PERF_EN, reset then 10 cycles including 1 redirect and 2 stalls -> perf_bubbles=2 and perf_fetched=6.
